// File: rtl/hdmi_seq_pkg.sv
// Shared state codes and constants for the HDMI output sequencer and its
// status/debug readout logic.
package hdmi_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_DIV_RST   = 3'd2,
        ST_SER_RST   = 3'd3,
        ST_RUN       = 3'd4
    } seq_state_e;

    localparam int STATE_W    = 3;
    localparam int LOSS_CNT_W = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hdmi_out_sequencer_if.sv
// Control/status bundle between the HDMI output sequencer and the path it
// manages; master is the sequencer side.
interface hdmi_out_sequencer_if #(
    parameter int N_OUT = 2
);
    logic                               pll_lock_i;
    logic [N_OUT-1:0]                   out_req_i;
    logic                               pll_reset_o;
    logic                               clkdiv_reset_o;
    logic                               ser_reset_o;
    logic [N_OUT-1:0]                   out_en_o;
    logic                               ready_o;
    logic [hdmi_seq_pkg::STATE_W-1:0]   state_o;
    logic [hdmi_seq_pkg::LOSS_CNT_W-1:0] lock_loss_cnt_o;

    modport master (
        input  pll_lock_i, out_req_i,
        output pll_reset_o, clkdiv_reset_o, ser_reset_o, out_en_o,
               ready_o, state_o, lock_loss_cnt_o
    );

    modport slave (
        output pll_lock_i, out_req_i,
        input  pll_reset_o, clkdiv_reset_o, ser_reset_o, out_en_o,
               ready_o, state_o, lock_loss_cnt_o
    );
endinterface

// File: rtl/hdmi_out_sequencer_sync_2ff.sv
// Two-flop synchronizer for slow level signals entering the board-clock domain.
module sync_2ff #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] sync_p0_q;
    logic [DATA_W-1:0] sync_p1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0_q <= '0;
            sync_p1_q <= '0;
        end else begin
            sync_p0_q <= d_i;
            sync_p1_q <= sync_p0_q;
        end
    end

    assign q_o = sync_p1_q;

endmodule

// File: rtl/hdmi_out_sequencer.sv
// Power-up/recovery sequencer for the HDMI output path: orders the PLL, divider
// and serializer resets behind a settled PLL lock and falls back on lock loss.
module hdmi_out_sequencer
    import hdmi_seq_pkg::*;
#(
    parameter int N_OUT            = 2,
    parameter int PLL_RST_CYC      = 64,
    parameter int LOCK_SETTLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 1048576,
    parameter int DIV_RST_CYC      = 16,
    parameter int SER_RST_CYC      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    hdmi_out_sequencer_if.master bus
);

    localparam int PHASE_MAX = max_int(max_int(PLL_RST_CYC, LOCK_TIMEOUT_CYC),
                                       max_int(DIV_RST_CYC, SER_RST_CYC));
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int SETTLE_W  = $clog2(LOCK_SETTLE_CYC + 1);

    localparam logic [PHASE_W-1:0]  PLL_LAST     = PHASE_W'(PLL_RST_CYC - 1);
    localparam logic [PHASE_W-1:0]  TIMEOUT_LAST = PHASE_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [PHASE_W-1:0]  DIV_LAST     = PHASE_W'(DIV_RST_CYC - 1);
    localparam logic [PHASE_W-1:0]  SER_LAST     = PHASE_W'(SER_RST_CYC - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST  = SETTLE_W'(LOCK_SETTLE_CYC - 1);

    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
        return (v == '1) ? v : v + LOSS_CNT_W'(1);
    endfunction

    logic lock_s;

    seq_state_e              state_q,  state_d;
    logic [PHASE_W-1:0]      phase_q,  phase_d;
    logic [SETTLE_W-1:0]     settle_q, settle_d;
    logic [LOSS_CNT_W-1:0]   loss_q,   loss_d;
    logic                    pll_rst_q,    pll_rst_d;
    logic                    clkdiv_rst_q, clkdiv_rst_d;
    logic                    ser_rst_q,    ser_rst_d;
    logic                    ready_q,      ready_d;
    logic [N_OUT-1:0]        en_q,         en_d;

    sync_2ff #(
        .DATA_W (1)
    ) u_lock_sync (
        .clk (clk),
        .rst (reset),
        .d_i (bus.pll_lock_i),
        .q_o (lock_s)
    );

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q + PHASE_W'(1);
        settle_d = '0;
        loss_d   = loss_q;

        case (state_q)
            ST_PLL_RST: begin
                if (phase_q == PLL_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) settle_d = settle_q + SETTLE_W'(1);
                // A settle completing on the timeout cycle still counts as a lock.
                if (lock_s && (settle_q == SETTLE_LAST)) begin
                    state_d = ST_DIV_RST;
                end else if (phase_q == TIMEOUT_LAST) begin
                    state_d = ST_PLL_RST;
                    loss_d  = sat_inc(loss_q);
                end
            end
            ST_DIV_RST: begin
                if (!lock_s) begin
                    state_d = ST_PLL_RST;
                    loss_d  = sat_inc(loss_q);
                end else if (phase_q == DIV_LAST) begin
                    state_d = ST_SER_RST;
                end
            end
            ST_SER_RST: begin
                if (!lock_s) begin
                    state_d = ST_PLL_RST;
                    loss_d  = sat_inc(loss_q);
                end else if (phase_q == SER_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                phase_d = phase_q;
                if (!lock_s) begin
                    state_d = ST_PLL_RST;
                    loss_d  = sat_inc(loss_q);
                end
            end
            default: begin
                state_d = ST_PLL_RST;
            end
        endcase

        if (state_d != state_q) begin
            phase_d  = '0;
            settle_d = '0;
        end

        // Outputs are registered from the next state so they move on the same edge.
        pll_rst_d    = (state_d == ST_PLL_RST);
        clkdiv_rst_d = (state_d == ST_PLL_RST) || (state_d == ST_WAIT_LOCK) ||
                       (state_d == ST_DIV_RST);
        ser_rst_d    = (state_d != ST_RUN);
        ready_d      = (state_d == ST_RUN);
        en_d         = ((state_q == ST_RUN) && (state_d == ST_RUN)) ? bus.out_req_i : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_PLL_RST;
            phase_q      <= '0;
            settle_q     <= '0;
            loss_q       <= '0;
            pll_rst_q    <= 1'b1;
            clkdiv_rst_q <= 1'b1;
            ser_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
            en_q         <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            settle_q     <= settle_d;
            loss_q       <= loss_d;
            pll_rst_q    <= pll_rst_d;
            clkdiv_rst_q <= clkdiv_rst_d;
            ser_rst_q    <= ser_rst_d;
            ready_q      <= ready_d;
            en_q         <= en_d;
        end
    end

    assign bus.pll_reset_o     = pll_rst_q;
    assign bus.clkdiv_reset_o  = clkdiv_rst_q;
    assign bus.ser_reset_o     = ser_rst_q;
    assign bus.ready_o         = ready_q;
    assign bus.out_en_o        = en_q;
    assign bus.state_o         = state_q;
    assign bus.lock_loss_cnt_o = loss_q;

endmodule
